pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-002 Port reset, input, 1: synchronous, active-high reset.
REQ-003 Ports IF_ID_Rs and IF_ID_Rt, input, 5 each: source register fields of the instruction in ID.
REQ-004 Ports ID_EX_RegWrite (1), ID_EX_MemRead (1) and ID_EX_Writereg (5), input: destination info of the instruction in EX.
REQ-005 Ports EX_MEM_RegWrite (1) and EX_MEM_Writereg (5), input: destination info of the instruction in MEM.
REQ-006 Port PCSrc, input, 1: branch taken, resolved in MEM.
REQ-007 Port PCWrite, output, 1: PC update enable.
REQ-008 Port IF_ID_Write, output, 1: IF/ID register load enable.
REQ-009 Port IF_ID_Flush, output, 1: zero IF/ID.
REQ-010 Port ID_EX_Bubble, output, 1: zero ID/EX control bits.
REQ-011 Port EX_MEM_Flush, output, 1: zero EX/MEM control bits.
REQ-012 Port stall_count, output, 16: cycles stalled since reset.

Function
REQ-013 FSM states: RUN, STALL, FLUSH.
REQ-014 Hazard match: a source field equals a destination field, the destination field is nonzero, and that stage's RegWrite is 1; register 0 never matches.
REQ-015 Required stalls: hz_ex (match on ID_EX) needs 2 stall cycles; hz_mem (match on EX_MEM) needs 1; when both apply, the larger value governs.
REQ-016 In RUN with a hazard: outputs PCWrite=0, IF_ID_Write=0 and ID_EX_Bubble=1 in the same cycle (combinational); remaining count = required-1; if remaining >0, load rem_cnt and go to STALL, else stay in RUN.
REQ-017 In STALL: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1; rem_cnt decrements each cycle; at rem_cnt==1, return to RUN next cycle.
REQ-018 PCSrc=1 in any state: IF_ID_Flush=1, ID_EX_Bubble=1, EX_MEM_Flush=1, PCWrite=1 and IF_ID_Write=1 that cycle; PCSrc has priority over any stall; an in-progress stall is aborted (rem_cnt cleared); next state is FLUSH.
REQ-019 FLUSH lasts exactly 1 cycle: all outputs take their idle values and hazard detection is suppressed; next state is RUN, unless PCSrc=1 again, in which case REQ-018 repeats.
REQ-020 Idle/RUN-without-hazard values: PCWrite=1, IF_ID_Write=1, flush and bubble signals 0.
REQ-021 stall_count increments by 1 on every cycle in which PCWrite=0; it saturates at 16'hFFFF with no wrap.
REQ-022 Hazard inputs are ignored while in STALL; the count loaded on entry governs.

Reset
REQ-023 reset=1 at a clock edge: state=RUN, rem_cnt=0 and stall_count=0; it overrides PCSrc and hazards in the same cycle.
REQ-024 While reset is asserted, outputs take the idle values of REQ-020; a stall in progress is discarded.

Configuration
REQ-025 Macro HAZARD_FORWARDING_EN.
- Defined: only load-use stalls; hz_ex counts only when ID_EX_MemRead=1 and requires 1 stall; hz_mem is ignored; STALL is never entered.
- Undefined: REQ-015 applies.

Structure
REQ-026 A shared package holds the state enum, STALLS_EX=2, STALLS_MEM=1 and the 16-bit counter width.
REQ-027 The sub-module hazard_detect is combinational match logic (returns the required stall count 0..2); the FSM, counters and output decode live in the top.

Verification
REQ-028 No forwarding; ID_EX_Writereg=8, RegWrite=1, IF_ID_Rs=8 -> PCWrite=0 for 2 cycles, then 1; stall_count=2.
REQ-029 No forwarding; EX_MEM_Writereg=9 matches Rt -> exactly 1 stall cycle.
REQ-030 Writereg=0 with Rs=0 and RegWrite=1 -> no stall.
REQ-031 PCSrc=1 during the 2nd stall cycle -> all three flush/bubble signals =1 and PCWrite=1 that cycle; 1 FLUSH cycle, then RUN; stall aborted.
REQ-032 HAZARD_FORWARDING_EN; ID_EX match with MemRead=0 -> no stall; with MemRead=1 -> 1 stall.
REQ-033 Force stall_count to 16'hFFFE and hold a hazard -> saturates at 16'hFFFF; reset mid-stall -> RUN, count 0, next cycle PCWrite=1.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// HAZARD_FORWARDING_EN selects load-use-only stalling.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam int STALLS_EX       = 2;
  localparam int STALLS_MEM      = 1;
  localparam int STALLS_LOAD_USE = 1;
  localparam int CNT_W           = 16;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational RAW match logic: reports how many stall cycles the ID instruction needs.
// With HAZARD_FORWARDING_EN only a load in EX forces a stall.
module hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  input  logic       id_ex_regwrite_i,
  input  logic       id_ex_memread_i,
  input  logic [4:0] id_ex_writereg_i,
  input  logic       ex_mem_regwrite_i,
  input  logic [4:0] ex_mem_writereg_i,
  output logic [1:0] req_stalls_o
);

  logic hz_ex;
  logic hz_mem;

  // Register 0 is hardwired to zero, so it never creates a dependency.
  assign hz_ex  = id_ex_regwrite_i && (id_ex_writereg_i != 5'd0) &&
                  ((id_ex_writereg_i == rs_i) || (id_ex_writereg_i == rt_i));
  assign hz_mem = ex_mem_regwrite_i && (ex_mem_writereg_i != 5'd0) &&
                  ((ex_mem_writereg_i == rs_i) || (ex_mem_writereg_i == rt_i));

`ifdef HAZARD_FORWARDING_EN
  logic unused_hz_mem;
  assign unused_hz_mem = hz_mem;
  assign req_stalls_o  = (hz_ex && id_ex_memread_i) ? 2'(STALLS_LOAD_USE) : 2'd0;
`else
  logic unused_memread;
  assign unused_memread = id_ex_memread_i;
  // The EX-stage distance is the larger requirement, so it is tested first.
  assign req_stalls_o   = hz_ex  ? 2'(STALLS_EX)  :
                          hz_mem ? 2'(STALLS_MEM) : 2'd0;
`endif

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stall/flush controller: RUN/STALL/FLUSH FSM, stall-cycle counter and control decode.
// Build option HAZARD_FORWARDING_EN limits stalls to load-use hazards.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IF_ID_Rs,
  input  logic [4:0]       IF_ID_Rt,
  input  logic             ID_EX_RegWrite,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_Writereg,
  input  logic             EX_MEM_RegWrite,
  input  logic [4:0]       EX_MEM_Writereg,
  input  logic             PCSrc,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic             EX_MEM_Flush,
  output logic [CNT_W-1:0] stall_count
);

  state_e           state_q, state_d;
  logic [1:0]       rem_q, rem_d;
  logic [CNT_W-1:0] stall_count_q;
  logic [1:0]       req_stalls;

  hazard_detect u_hazard_detect (
    .rs_i              (IF_ID_Rs),
    .rt_i              (IF_ID_Rt),
    .id_ex_regwrite_i  (ID_EX_RegWrite),
    .id_ex_memread_i   (ID_EX_MemRead),
    .id_ex_writereg_i  (ID_EX_Writereg),
    .ex_mem_regwrite_i (EX_MEM_RegWrite),
    .ex_mem_writereg_i (EX_MEM_Writereg),
    .req_stalls_o      (req_stalls)
  );

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no path infers a latch.
    state_d      = state_q;
    rem_d        = rem_q;
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    EX_MEM_Flush = 1'b0;

    if (reset) begin
      state_d = ST_RUN;
      rem_d   = 2'd0;
    end else if (PCSrc) begin
      // A taken branch squashes the wrong-path instructions and aborts any stall.
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
      EX_MEM_Flush = 1'b1;
      state_d      = ST_FLUSH;
      rem_d        = 2'd0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (req_stalls != 2'd0) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
            if (req_stalls > 2'd1) begin
              rem_d   = req_stalls - 2'd1;
              state_d = ST_STALL;
            end
          end
        end
        ST_STALL: begin
          PCWrite      = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_Bubble = 1'b1;
          rem_d        = rem_q - 2'd1;
          if (rem_q == 2'd1) state_d = ST_RUN;
        end
        ST_FLUSH: state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      rem_q         <= 2'd0;
      stall_count_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      if (!PCWrite && (stall_count_q != '1)) stall_count_q <= stall_count_q + 1'b1;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl with a scoreboard queue of expected outputs.
// Expectations follow HAZARD_FORWARDING_EN when it is defined.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  IF_ID_Rs, IF_ID_Rt, ID_EX_Writereg, EX_MEM_Writereg;
  logic        ID_EX_RegWrite, ID_EX_MemRead, EX_MEM_RegWrite, PCSrc;
  logic        PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_MEM_Flush;
  logic [15:0] stall_count;

  int compared = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [4:0]  ctl;  // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_MEM_Flush}
    logic [15:0] cnt;
  } obs_t;

  obs_t sb[$];

  localparam logic [4:0] IDLE  = 5'b11000;
  localparam logic [4:0] STALL = 5'b00010;
  localparam logic [4:0] FLUSH = 5'b11111;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .IF_ID_Rs        (IF_ID_Rs),
    .IF_ID_Rt        (IF_ID_Rt),
    .ID_EX_RegWrite  (ID_EX_RegWrite),
    .ID_EX_MemRead   (ID_EX_MemRead),
    .ID_EX_Writereg  (ID_EX_Writereg),
    .EX_MEM_RegWrite (EX_MEM_RegWrite),
    .EX_MEM_Writereg (EX_MEM_Writereg),
    .PCSrc           (PCSrc),
    .PCWrite         (PCWrite),
    .IF_ID_Write     (IF_ID_Write),
    .IF_ID_Flush     (IF_ID_Flush),
    .ID_EX_Bubble    (ID_EX_Bubble),
    .EX_MEM_Flush    (EX_MEM_Flush),
    .stall_count     (stall_count)
  );

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic idrw, input logic idmr, input logic [4:0] idwr,
                       input logic emrw, input logic [4:0] emwr, input logic br);
    IF_ID_Rs        = rs;
    IF_ID_Rt        = rt;
    ID_EX_RegWrite  = idrw;
    ID_EX_MemRead   = idmr;
    ID_EX_Writereg  = idwr;
    EX_MEM_RegWrite = emrw;
    EX_MEM_Writereg = emwr;
    PCSrc           = br;
  endtask

  task automatic idle_in();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  // Push the expectation for the current cycle, compare once inputs settle, then advance a clock.
  task automatic step(input string tag, input logic [4:0] ctl, input logic [15:0] cnt);
    obs_t exp_v, obs_v;
    sb.push_back('{ctl: ctl, cnt: cnt});
    #1;
    exp_v = sb.pop_front();
    obs_v = '{ctl: {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_MEM_Flush},
              cnt: stall_count};
    compared++;
    assert (obs_v === exp_v) else begin
      mismatched++;
      $display("FAIL %s: observed ctl=%b cnt=%h, expected ctl=%b cnt=%h",
               tag, obs_v.ctl, obs_v.cnt, exp_v.ctl, exp_v.cnt);
      $error("compare %s mismatched", tag);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    idle_in();
    @(posedge clk);
    @(negedge clk);

    // Reset overrides a branch and a hazard in the same cycle.
    drive(5'd8, 5'd0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b1);
    step("reset_idle", IDLE, 16'd0);
    reset = 1'b0;

    // Register 0 never matches.
    drive(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0);
    step("r0_no_stall", IDLE, 16'd0);

`ifndef HAZARD_FORWARDING_EN
    // EX-stage match: two stall cycles, inputs during STALL are ignored.
    drive(5'd8, 5'd0, 1'b1, 1'b0, 5'd8, 1'b0, 5'd0, 1'b0);
    step("ex_stall1", STALL, 16'd0);
    step("ex_stall2", STALL, 16'd1);
    idle_in();
    step("ex_release", IDLE, 16'd2);

    // MEM-stage match requires RegWrite, then gives one stall cycle.
    drive(5'd0, 5'd9, 1'b0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b0);
    step("mem_nowrite", IDLE, 16'd2);
    drive(5'd0, 5'd9, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0);
    step("mem_stall1", STALL, 16'd2);
    idle_in();
    step("mem_release", IDLE, 16'd3);

    // Both stages match: the larger requirement governs.
    drive(5'd8, 5'd9, 1'b1, 1'b0, 5'd8, 1'b1, 5'd9, 1'b0);
    step("both_stall1", STALL, 16'd3);
    idle_in();
    step("both_stall2", STALL, 16'd4);
    step("both_release", IDLE, 16'd5);

    // Branch during the second stall cycle aborts the stall.
    drive(5'd8, 5'd0, 1'b1, 1'b0, 5'd8, 1'b0, 5'd0, 1'b0);
    step("br_stall1", STALL, 16'd5);
    idle_in();
    PCSrc = 1'b1;
    step("br_flush", FLUSH, 16'd6);
    drive(5'd8, 5'd0, 1'b1, 1'b0, 5'd8, 1'b0, 5'd0, 1'b0);
    step("flush_suppress", IDLE, 16'd6);
    idle_in();
    step("flush_to_run", IDLE, 16'd6);

    // Branch beats a fresh hazard in RUN, and back-to-back branches re-flush.
    drive(5'd8, 5'd0, 1'b1, 1'b0, 5'd8, 1'b0, 5'd0, 1'b1);
    step("br_over_hz", FLUSH, 16'd6);
    idle_in();
    PCSrc = 1'b1;
    step("br_in_flush", FLUSH, 16'd6);
    PCSrc = 1'b0;
    step("flush_idle", IDLE, 16'd6);
    step("run_idle", IDLE, 16'd6);

    // Reset in the middle of a stall discards it.
    drive(5'd8, 5'd0, 1'b1, 1'b0, 5'd8, 1'b0, 5'd0, 1'b0);
    step("rst_stall1", STALL, 16'd6);
    reset = 1'b1;
    step("rst_mid_stall", IDLE, 16'd7);
`else
    // Forwarding: an EX match without MemRead needs no stall.
    drive(5'd8, 5'd0, 1'b1, 1'b0, 5'd8, 1'b0, 5'd0, 1'b0);
    step("fwd_alu_ok", IDLE, 16'd0);
    // Load-use: one stall cycle, STALL never entered.
    drive(5'd8, 5'd0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0);
    step("fwd_load_use", STALL, 16'd0);
    idle_in();
    step("fwd_release", IDLE, 16'd1);
    // MEM-stage match is covered by forwarding.
    drive(5'd0, 5'd9, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0);
    step("fwd_mem_ok", IDLE, 16'd1);

    idle_in();
    PCSrc = 1'b1;
    step("fwd_br_flush", FLUSH, 16'd1);
    drive(5'd8, 5'd0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0);
    step("fwd_flush_supp", IDLE, 16'd1);
    idle_in();
    step("fwd_run_idle", IDLE, 16'd1);

    drive(5'd8, 5'd0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0);
    step("fwd_rst_stall", STALL, 16'd1);
    reset = 1'b1;
    step("rst_mid_stall", IDLE, 16'd2);
`endif

    reset = 1'b0;
    idle_in();
    step("post_rst_run", IDLE, 16'd0);

    // Hold a load-use hazard long enough to saturate the counter.
    drive(5'd8, 5'd0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0);
    step("sat_start", STALL, 16'd0);
    for (int i = 0; i < 65533; i++) @(posedge clk);
    @(negedge clk);
    step("sat_fffe", STALL, 16'hFFFE);
    step("sat_ffff", STALL, 16'hFFFF);
    step("sat_hold", STALL, 16'hFFFF);

    reset = 1'b1;
    step("sat_rst", IDLE, 16'hFFFF);
    reset = 1'b0;
    idle_in();
    step("sat_rst_clr", IDLE, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
